gpio_ber_ctrl: RTL and testbench
================================

// Module: gpio_ber_ctrl
// PURPOSE
//  - Command controller between the MicroBlaze GPIO pair (gpo0/gpi0) and the I/Q PRBS9+BPSK+RC+BER datapath.
//  - Decodes host commands to drive tx_enable, rx_enable, offset and a soft reset.
//  - Snapshots the four 64-bit BER counters atomically and returns them as 32-bit words on gpi0.
//  - Sits in top, replacing direct switch/VIO control when the host owns the link.
// PARAMETERS
//  - NB_GPIOS   32  GPIO word width; fixed at 32 for this command map
//  - NB_CNT     64  BER counter width
//  - RST_CYCLES 16  soft-reset pulse length in clocks; range 1..255
// PORTS
//  - clock           in   1       system clock; all logic on rising edge
//  - i_reset         in   1       asynchronous, active-low reset
//  - i_gpo           in   32      host word: [31:24] cmd, [23] strobe, [22:0] arg
//  - i_bit_count_i   in   64      bit counter, I branch
//  - i_err_count_i   in   64      error counter, I branch
//  - i_bit_count_q   in   64      bit counter, Q branch
//  - i_err_count_q   in   64      error counter, Q branch
//  - o_gpi           out  32      response word to host
//  - o_tx_enable     out  1       TX enable to both branches
//  - o_rx_enable     out  1       RX enable to both branches
//  - o_offset        out  2       RX sampling phase, 0..OS-1
//  - o_soft_reset    out  1       active-high reset pulse to datapath
// BEHAVIOUR
//  - Async reset (i_reset=0): o_gpi=0, o_tx_enable=0, o_rx_enable=0, o_offset=0, o_soft_reset=0.
//    Snapshot regs=0, FSM=IDLE, strobe sync regs=0.
//  - Strobe i_gpo[23] passes a 2-FF synchronizer, then a rising-edge detector.
//    cmd and arg are sampled only on the detected edge; the host holds them stable while strobe=1.
//  - FSM states:
//    - IDLE: on strobe rise, latch cmd/arg, go to EXEC.
//    - EXEC: one cycle. Perform cmd and write o_gpi.
//      Go to RST if cmd=0x00, else WAIT_LOW.
//    - RST: o_soft_reset=1 for exactly RST_CYCLES clocks (8-bit down-counter), then WAIT_LOW.
//    - WAIT_LOW: hold until synced strobe=0, then IDLE.
//      A new command is accepted only after strobe returns low.
//  - Latency: o_gpi is valid 4 clocks after i_gpo[23] rises (2 sync + edge/latch + EXEC).
//    o_gpi holds its value until the next EXEC.
//  - Commands (o_gpi written in EXEC):
//    - 0x00 SOFT_RST: pulse reset. o_gpi=0x0000_0000. tx/rx/offset are unchanged.
//    - 0x01 SET_EN: o_tx_enable=arg[0], o_rx_enable=arg[1]. o_gpi={30'b0,arg[1:0]}.
//    - 0x02 SET_OFS: o_offset=arg[1:0]. o_gpi={30'b0,arg[1:0]}.
//    - 0x03 SNAPSHOT: all four counters are captured in the same cycle. o_gpi=0x0000_0001.
//    - 0x04..0x0B READ: return a snapshot word. Word index = cmd-4, order:
//      bitI lo, bitI hi, errI lo, errI hi, bitQ lo, bitQ hi, errQ lo, errQ hi.
//      lo=[31:0], hi=[63:32]. READ never triggers a capture.
//    - 0x0C STATUS: o_gpi={27'b0, err_zero, o_offset, o_rx_enable, o_tx_enable}.
//      err_zero=1 iff both live error counters are 0.
//    - other: o_gpi=0xDEAD_00,cmd (i.e. {16'hDEAD,8'h00,cmd}). No state change.
//  - Reads return the last snapshot even if the counters have since wrapped or been reset.
//    READ before any SNAPSHOT returns 0.
//  - A strobe held high never re-triggers.
//    A strobe pulse shorter than 2 clocks may be missed; the host must hold strobe >=3 clocks.
//  - During RST, strobe edges are ignored. After RST the FSM still requires strobe low before accepting.
//  - Async reset mid-RST terminates the pulse immediately (o_soft_reset=0).
// TESTING
//  - Reset: assert i_reset=0 mid-RST -> all outputs 0 at once, FSM IDLE, o_soft_reset drops without a clock.
//  - SET_EN arg=0x3, then SET_OFS arg=0x2 -> tx=1, rx=1, offset=2. o_gpi=0x3, then 0x2, each 4 clocks after strobe.
//  - bitI=0x0000_0001_8000_0000: SNAPSHOT, change counters, READ 0x04/0x05 -> 0x8000_0000 / 0x0000_0001.
//  - SOFT_RST with RST_CYCLES=16 -> o_soft_reset high exactly 16 clocks. Strobe toggles meanwhile are ignored.
//  - Strobe held high 100 clocks -> exactly one EXEC. Cmd 0x7F -> o_gpi=0xDEAD_007F, enables unchanged.
//  - STATUS with errI=errQ=0, tx=1, rx=0, offset=3 -> o_gpi=0x0000_001D.

Source files
------------

// File: rtl/gpio_ber_ctrl_if.sv
// Host GPIO word pair: gpo carries {cmd, strobe, arg} from the host, gpi returns the response word.
// Master is the host (MicroBlaze side); slave is the command controller.
interface gpio_ber_ctrl_if #(
    parameter int NB_GPIOS = 32
);
    logic [NB_GPIOS-1:0] gpo;
    logic [NB_GPIOS-1:0] gpi;

    modport master (output gpo, input gpi);
    modport slave  (input gpo, output gpi);
endinterface

// File: rtl/gpio_ber_ctrl.sv
// Host command decoder for the PRBS/BER datapath: enables, RX phase, soft reset, atomic counter snapshots.
// Response on gpi 4 clocks after strobe rise; one command per strobe, next accepted only after strobe drops.
module gpio_ber_ctrl #(
    parameter int NB_GPIOS   = 32,
    parameter int NB_CNT     = 64,
    parameter int RST_CYCLES = 16
) (
    input  logic              clock,
    input  logic              i_reset,
    gpio_ber_ctrl_if.slave    bus,
    input  logic [NB_CNT-1:0] i_bit_count_i,
    input  logic [NB_CNT-1:0] i_err_count_i,
    input  logic [NB_CNT-1:0] i_bit_count_q,
    input  logic [NB_CNT-1:0] i_err_count_q,
    output logic              o_tx_enable,
    output logic              o_rx_enable,
    output logic [1:0]        o_offset,
    output logic              o_soft_reset
);
    typedef enum logic [1:0] {IDLE, EXEC, RST, WAIT_LOW} state_t;

    localparam logic [7:0] RST_LOAD = 8'(RST_CYCLES - 1);

    state_t            state;
    logic [2:0]        stb_sync;
    logic [7:0]        cmd;
    logic [1:0]        arg;
    logic [7:0]        rst_cnt;
    logic [NB_CNT-1:0] snap [4];

    logic              stb_s;
    logic              stb_rise;
    logic              err_zero;
    logic [2:0]        widx;
    logic [NB_CNT-1:0] sel;
    logic [31:0]       rd_word;

    // stb_sync[1:0] is the 2-FF synchronizer; stb_sync[2] is the previous synced value for edge detect
    assign stb_s    = stb_sync[1];
    assign stb_rise = stb_sync[1] & ~stb_sync[2];
    assign err_zero = (i_err_count_i == '0) && (i_err_count_q == '0);

    always_comb begin
        widx    = 3'(cmd - 8'd4);
        sel     = snap[widx[2:1]];
        rd_word = widx[0] ? sel[63:32] : sel[31:0];
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state        <= IDLE;
            stb_sync     <= '0;
            cmd          <= '0;
            arg          <= '0;
            rst_cnt      <= '0;
            for (int i = 0; i < 4; i++) snap[i] <= '0;
            bus.gpi      <= '0;
            o_tx_enable  <= 1'b0;
            o_rx_enable  <= 1'b0;
            o_offset     <= 2'd0;
            o_soft_reset <= 1'b0;
        end else begin
            stb_sync <= {stb_sync[1:0], bus.gpo[23]};
            case (state)
                IDLE: begin
                    if (stb_rise) begin
                        cmd   <= bus.gpo[31:24];
                        arg   <= bus.gpo[1:0];
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    state <= WAIT_LOW;
                    case (cmd)
                        8'h00: begin
                            bus.gpi      <= '0;
                            o_soft_reset <= 1'b1;
                            rst_cnt      <= RST_LOAD;
                            state        <= RST;
                        end
                        8'h01: begin
                            o_tx_enable <= arg[0];
                            o_rx_enable <= arg[1];
                            bus.gpi     <= {30'b0, arg};
                        end
                        8'h02: begin
                            o_offset <= arg;
                            bus.gpi  <= {30'b0, arg};
                        end
                        8'h03: begin
                            // all four captured on the same edge so bit/err pairs stay consistent
                            snap[0] <= i_bit_count_i;
                            snap[1] <= i_err_count_i;
                            snap[2] <= i_bit_count_q;
                            snap[3] <= i_err_count_q;
                            bus.gpi <= 32'h0000_0001;
                        end
                        8'h04, 8'h05, 8'h06, 8'h07,
                        8'h08, 8'h09, 8'h0A, 8'h0B: bus.gpi <= rd_word;
                        8'h0C: bus.gpi <= {27'b0, err_zero, o_offset, o_rx_enable, o_tx_enable};
                        default: bus.gpi <= {16'hDEAD, 8'h00, cmd};
                    endcase
                end
                RST: begin
                    if (rst_cnt == 8'd0) begin
                        o_soft_reset <= 1'b0;
                        state        <= WAIT_LOW;
                    end else begin
                        rst_cnt <= rst_cnt - 8'd1;
                    end
                end
                WAIT_LOW: begin
                    if (!stb_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gpio_ber_ctrl.sv
// Directed and randomized host command sequences checked against a command-level reference model.
module tb_gpio_ber_ctrl;
    localparam int RST_CYCLES = 16;

    logic        clock;
    logic        i_reset;
    logic [63:0] cnt [4];   // bitI, errI, bitQ, errQ
    logic        tx_enable, rx_enable, soft_reset;
    logic [1:0]  offset;

    gpio_ber_ctrl_if #(.NB_GPIOS(32)) bus ();

    gpio_ber_ctrl #(.NB_GPIOS(32), .NB_CNT(64), .RST_CYCLES(RST_CYCLES)) dut (
        .clock         (clock),
        .i_reset       (i_reset),
        .bus           (bus.slave),
        .i_bit_count_i (cnt[0]),
        .i_err_count_i (cnt[1]),
        .i_bit_count_q (cnt[2]),
        .i_err_count_q (cnt[3]),
        .o_tx_enable   (tx_enable),
        .o_rx_enable   (rx_enable),
        .o_offset      (offset),
        .o_soft_reset  (soft_reset)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [31:0] m_gpi;
    logic        m_tx, m_rx;
    logic [1:0]  m_ofs;
    logic [63:0] m_snap [4];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_gpi = 0; m_tx = 0; m_rx = 0; m_ofs = 0;
        for (int i = 0; i < 4; i++) m_snap[i] = 0;
    endtask

    task automatic model_exec(input logic [7:0] c, input logic [22:0] a);
        int w;
        logic [63:0] v;
        if (c == 8'h00) m_gpi = 0;
        else if (c == 8'h01) begin
            m_tx = a[0]; m_rx = a[1]; m_gpi = 32'(a[1:0]);
        end else if (c == 8'h02) begin
            m_ofs = a[1:0]; m_gpi = 32'(a[1:0]);
        end else if (c == 8'h03) begin
            for (int i = 0; i < 4; i++) m_snap[i] = cnt[i];
            m_gpi = 1;
        end else if (c >= 8'h04 && c <= 8'h0B) begin
            w = int'(c) - 4;
            v = m_snap[w / 2];
            m_gpi = (w % 2 == 1) ? v[63:32] : v[31:0];
        end else if (c == 8'h0C) begin
            m_gpi = 32'(((cnt[1] == 0 && cnt[3] == 0) ? 16 : 0) + int'(m_ofs) * 4 + int'(m_rx) * 2 + int'(m_tx));
        end else begin
            m_gpi = 32'hDEAD_0000 + 32'(c);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_gpi"}, 64'(bus.gpi), 64'(m_gpi));
        check({tag, "_tx"},  64'(tx_enable), 64'(m_tx));
        check({tag, "_rx"},  64'(rx_enable), 64'(m_rx));
        check({tag, "_ofs"}, 64'(offset), 64'(m_ofs));
    endtask

    // Issue one command; strobe held for 4+hold clocks (toggle: dropped then pulsed during the window).
    task automatic send(input logic [7:0] c, input logic [22:0] a, input int hold, input bit toggle);
        int   high;
        int   rises;
        logic prev;
        high = 0; rises = 0;
        @(negedge clock);
        bus.gpo = {c, 1'b1, a};
        prev = soft_reset;
        repeat (3) @(negedge clock);
        check("gpi_before_latency", 64'(bus.gpi), 64'(m_gpi));
        @(negedge clock);
        model_exec(c, a);
        check_outputs("exec");
        for (int k = 0; k < hold + 30; k++) begin
            if (soft_reset) high++;
            if (soft_reset && !prev) rises++;
            prev = soft_reset;
            if (k == hold) bus.gpo[23] = 1'b0;
            if (toggle && k >= 2 && k <= 9) bus.gpo[23] = (k % 2 == 0);
            @(negedge clock);
        end
        check("soft_reset_clocks", 64'(high), (c == 8'h00) ? 64'(RST_CYCLES) : 64'd0);
        check("soft_reset_pulses", 64'(rises), (c == 8'h00) ? 64'd1 : 64'd0);
        check_outputs("after");
    endtask

    initial begin
        logic [7:0]  c;
        logic [22:0] a;
        int          r;

        i_reset = 1'b1;
        bus.gpo = '0;
        for (int i = 0; i < 4; i++) cnt[i] = '0;
        model_reset();
        #3 i_reset = 1'b0;
        #2;
        check_outputs("reset");
        check("reset_soft_rst", 64'(soft_reset), 64'd0);
        @(negedge clock);
        i_reset = 1'b1;
        repeat (2) @(negedge clock);

        send(8'h01, 23'h3, 3, 0);
        send(8'h02, 23'h2, 3, 0);

        cnt[0] = 64'h0000_0001_8000_0000;
        send(8'h03, 23'h0, 3, 0);
        cnt[0] = 64'hFFFF_FFFF_0000_1234;
        send(8'h04, 23'h0, 3, 0);
        check("read_bitI_lo", 64'(bus.gpi), 64'h8000_0000);
        send(8'h05, 23'h0, 3, 0);
        check("read_bitI_hi", 64'(bus.gpi), 64'h0000_0001);

        send(8'h00, 23'h0, 0, 1);
        send(8'h00, 23'h0, 100, 0);
        send(8'h7F, 23'h7F_FFFF, 100, 0);
        check("bad_cmd", 64'(bus.gpi), 64'hDEAD_007F);

        send(8'h01, 23'h1, 3, 0);
        send(8'h02, 23'h3, 3, 0);
        cnt[1] = 0; cnt[3] = 0;
        send(8'h0C, 23'h0, 3, 0);
        check("status_1d", 64'(bus.gpi), 64'h0000_001D);

        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 4; i++) cnt[i] = {$urandom, $urandom};
            if ($urandom_range(0, 2) == 0) begin cnt[1] = 0; cnt[3] = 0; end
            r = $urandom_range(0, 15);
            a = 23'($urandom);
            if (r <= 1)       c = 8'h01;
            else if (r == 2)  c = 8'h02;
            else if (r <= 4)  c = 8'h03;
            else if (r <= 10) c = 8'(4 + $urandom_range(0, 7));
            else if (r == 11) c = 8'h0C;
            else if (r == 12) c = 8'($urandom_range(13, 255));
            else if (r == 13) c = 8'h00;
            else              c = 8'h01;
            send(c, a, $urandom_range(0, 5), 0);
        end

        cnt[0] = {32'h0000_0001, $urandom | 32'h1};
        send(8'h03, 23'h0, 3, 0);
        send(8'h01, 23'h3, 3, 0);
        @(negedge clock);
        bus.gpo = {8'h00, 1'b1, 23'h0};
        repeat (6) @(negedge clock);
        check("pulse_before_arst", 64'(soft_reset), 64'd1);
        #2 i_reset = 1'b0;
        #1;
        model_reset();
        check("arst_soft_rst", 64'(soft_reset), 64'd0);
        check_outputs("arst");
        bus.gpo = '0;
        @(negedge clock);
        i_reset = 1'b1;
        repeat (2) @(negedge clock);
        send(8'h05, 23'h0, 3, 0);
        check("read_after_arst", 64'(bus.gpi), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
